// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle datapath: ALU ops, immediate formats,
// mux selects and load/store width codes.
package mc_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'd0,
    SRCA_OLDPC = 2'd1,
    SRCA_A     = 2'd2
  } srca_e;

  typedef enum logic [1:0] {
    SRCB_WDATA = 2'd0,
    SRCB_IMM   = 2'd1,
    SRCB_FOUR  = 2'd2
  } srcb_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'd0,
    RES_DATA      = 2'd1,
    RES_ALURESULT = 2'd2,
    RES_IMMEXT    = 2'd3
  } res_src_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // funct3 width codes shared by loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

endpackage

// File: rtl/mc_regfile.sv
// Register file: two combinational read ports, one write port, x0 hardwired to zero.
module mc_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [4:0]      ra1_i,
  input  logic [4:0]      ra2_i,
  input  logic [4:0]      wa_i,
  input  logic [XLEN-1:0] wd_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != 5'd0) && (int'(wa_i) < NREG)) begin
      regs_q[wa_i[AW-1:0]] <= wd_i;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded
  always_comb begin
    rd1_o = '0;
    rd2_o = '0;
    if ((ra1_i != 5'd0) && (int'(ra1_i) < NREG)) rd1_o = regs_q[ra1_i[AW-1:0]];
    if ((ra2_i != 5'd0) && (int'(ra2_i) < NREG)) rd2_o = regs_q[ra2_i[AW-1:0]];
  end

endmodule

// File: rtl/mc_datapath_hs.sv
// Multicycle RISC-V datapath with a req/ack memory bus; a pending access
// (MemStrobe without BusAck) freezes every architectural register.
module mc_datapath_hs
  import mc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              AdrSrc,
  input  logic              IRWrite,
  input  logic              PCWrite,
  input  logic              RegWrite,
  input  logic              MemWrite,
  input  logic              MemStrobe,
  input  logic [1:0]        ALUSrcA,
  input  logic [1:0]        ALUSrcB,
  input  logic [1:0]        ResultSrc,
  input  logic [2:0]        ImmSrc,
  input  logic [3:0]        ALUControl,
  output logic [XLEN-1:0]   BusAddr,
  output logic [XLEN-1:0]   BusWData,
  output logic [XLEN/8-1:0] BusBE,
  output logic              BusWE,
  output logic              BusReq,
  input  logic [XLEN-1:0]   BusRData,
  input  logic              BusAck,
  output logic [6:0]        OP,
  output logic [2:0]        funct3,
  output logic              funct7b5,
  output logic              Zero,
  output logic              Stall
);

  localparam int BW = XLEN / 8;
  localparam int LW = $clog2(BW);
  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] pc_q, pc_d, oldpc_q, oldpc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] a_q, a_d, wdata_q, wdata_d;
  logic [XLEN-1:0] aluout_q, aluout_d, data_q, data_d;

  logic [XLEN-1:0] rd1, rd2, imm_ext, srca, srcb, alu_result, result;
  logic [XLEN-1:0] rdata_sh, load_fmt, st_wdata;
  logic [BW-1:0]   st_be;
  logic [LW-1:0]   lane;
  logic [SW-1:0]   shamt;
  logic            misaligned;

  assign OP       = instr_q[6:0];
  assign funct3   = instr_q[14:12];
  assign funct7b5 = instr_q[30];
  assign Stall    = MemStrobe & ~BusAck;

  mc_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .we_i   (RegWrite & ~Stall),
    .ra1_i  (instr_q[19:15]),
    .ra2_i  (instr_q[24:20]),
    .wa_i   (instr_q[11:7]),
    .wd_i   (result),
    .rd1_o  (rd1),
    .rd2_o  (rd2)
  );

  always_comb begin
    imm_ext = '0;
    case (ImmSrc)
      IMM_I:   imm_ext = XLEN'($signed(instr_q[31:20]));
      IMM_S:   imm_ext = XLEN'($signed({instr_q[31:25], instr_q[11:7]}));
      IMM_B:   imm_ext = XLEN'($signed({instr_q[31], instr_q[7], instr_q[30:25],
                                        instr_q[11:8], 1'b0}));
      IMM_U:   imm_ext = XLEN'($signed({instr_q[31:12], 12'b0}));
      IMM_J:   imm_ext = XLEN'($signed({instr_q[31], instr_q[19:12], instr_q[20],
                                        instr_q[30:21], 1'b0}));
      default: imm_ext = '0;
    endcase
  end

  always_comb begin
    srca = '0;
    srcb = '0;
    case (ALUSrcA)
      SRCA_PC:    srca = pc_q;
      SRCA_OLDPC: srca = oldpc_q;
      SRCA_A:     srca = a_q;
      default:    srca = '0;
    endcase
    case (ALUSrcB)
      SRCB_WDATA: srcb = wdata_q;
      SRCB_IMM:   srcb = imm_ext;
      SRCB_FOUR:  srcb = XLEN'(4);
      default:    srcb = '0;
    endcase
  end

  assign shamt = srcb[SW-1:0];

  always_comb begin
    alu_result = '0;
    case (ALUControl)
      ALU_ADD:  alu_result = srca + srcb;
      ALU_SUB:  alu_result = srca - srcb;
      ALU_AND:  alu_result = srca & srcb;
      ALU_OR:   alu_result = srca | srcb;
      ALU_XOR:  alu_result = srca ^ srcb;
      ALU_SLT:  alu_result = XLEN'($signed(srca) < $signed(srcb));
      ALU_SLTU: alu_result = XLEN'(srca < srcb);
      ALU_SLL:  alu_result = srca << shamt;
      ALU_SRL:  alu_result = srca >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(srca) >>> shamt);
      default:  alu_result = '0;
    endcase
  end

  assign Zero = (alu_result == '0);

  always_comb begin
    result = '0;
    case (ResultSrc)
      RES_ALUOUT:    result = aluout_q;
      RES_DATA:      result = data_q;
      RES_ALURESULT: result = alu_result;
      RES_IMMEXT:    result = imm_ext;
      default:       result = '0;
    endcase
  end

  assign BusAddr = AdrSrc ? result : pc_q;
  assign BusReq  = MemStrobe;
  // The address is held stable for the whole access, so its low bits are the lane
  assign lane    = BusAddr[LW-1:0];

  assign rdata_sh = BusRData >> {lane, 3'b000};

  always_comb begin
    load_fmt = rdata_sh;
    case (funct3)
      F3_B:    load_fmt = XLEN'($signed(rdata_sh[7:0]));
      F3_H:    load_fmt = XLEN'($signed(rdata_sh[15:0]));
      F3_W:    load_fmt = XLEN'($signed(rdata_sh[31:0]));
      F3_D:    load_fmt = rdata_sh;
      F3_BU:   load_fmt = XLEN'(rdata_sh[7:0]);
      F3_HU:   load_fmt = XLEN'(rdata_sh[15:0]);
      F3_WU:   load_fmt = XLEN'(rdata_sh[31:0]);
      default: load_fmt = rdata_sh;
    endcase
  end

  always_comb begin
    st_be      = '0;
    st_wdata   = wdata_q;
    misaligned = 1'b0;
    case (funct3)
      F3_B: begin
        st_be    = BW'(1) << lane;
        st_wdata = {BW{wdata_q[7:0]}};
      end
      F3_H: begin
        misaligned = lane[0];
        st_be      = BW'(3) << lane;
        st_wdata   = {(XLEN/16){wdata_q[15:0]}};
      end
      F3_W: begin
        misaligned = |lane[1:0];
        st_be      = BW'(15) << lane;
        st_wdata   = {(XLEN/32){wdata_q[31:0]}};
      end
      F3_D: begin
        misaligned = (XLEN != 64) || (|lane);
        st_be      = '1;
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign BusWData = st_wdata;
  assign BusBE    = MemWrite ? (misaligned ? '0 : st_be) : '1;
  assign BusWE    = MemWrite & MemStrobe & ~misaligned;

  always_comb begin
    pc_d     = pc_q;
    oldpc_d  = oldpc_q;
    instr_d  = instr_q;
    a_d      = a_q;
    wdata_d  = wdata_q;
    aluout_d = aluout_q;
    data_d   = data_q;
    if (!Stall) begin
      if (PCWrite) pc_d = result;
      if (IRWrite) begin
        instr_d = BusRData[31:0];
        oldpc_d = pc_q;
      end
      a_d      = rd1;
      wdata_d  = rd2;
      aluout_d = alu_result;
      data_d   = load_fmt;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q     <= RESET_PC;
      oldpc_q  <= '0;
      instr_q  <= NOP_INSTR;
      a_q      <= '0;
      wdata_q  <= '0;
      aluout_q <= '0;
      data_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      oldpc_q  <= oldpc_d;
      instr_q  <= instr_d;
      a_q      <= a_d;
      wdata_q  <= wdata_d;
      aluout_q <= aluout_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_mc_datapath_hs.sv
// Directed bench for mc_datapath_hs: sequences the control inputs by hand as a
// multicycle controller would and checks bus-visible results.
module tb_mc_datapath_hs;
  import mc_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, MemStrobe;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic [31:0] BusAddr, BusWData, BusRData;
  logic [3:0]  BusBE;
  logic        BusWE, BusReq, BusAck;
  logic [6:0]  OP;
  logic [2:0]  funct3;
  logic        funct7b5, Zero, Stall;

  int          n_vec;
  int          n_miss;
  logic [31:0] exp_pc;

  mc_datapath_hs #(.XLEN(32), .NREG(32), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RESET(RESET), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .MemStrobe(MemStrobe),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .BusAddr(BusAddr), .BusWData(BusWData), .BusBE(BusBE),
    .BusWE(BusWE), .BusReq(BusReq), .BusRData(BusRData), .BusAck(BusAck),
    .OP(OP), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero), .Stall(Stall)
  );

  always #5 CLK = ~CLK;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic idle();
    AdrSrc = 0; IRWrite = 0; PCWrite = 0; RegWrite = 0; MemWrite = 0; MemStrobe = 0;
    ALUSrcA = SRCA_PC; ALUSrcB = SRCB_WDATA; ResultSrc = RES_ALUOUT; ImmSrc = IMM_I;
    ALUControl = ALU_ADD; BusAck = 0; BusRData = '0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Fetch with ack after `delay` stalled cycles, then one decode cycle
  task automatic fetch(input logic [31:0] word, input int delay);
    idle();
    MemStrobe = 1; IRWrite = 1; PCWrite = 1;
    ALUSrcA = SRCA_PC; ALUSrcB = SRCB_FOUR; ALUControl = ALU_ADD; ResultSrc = RES_ALURESULT;
    BusRData = word;
    for (int d = 0; d < delay; d++) begin
      BusAck = 0;
      #1;
      check_vec("fetch_stall", {63'd0, Stall}, 64'd1);
      check_vec("fetch_pc_hold", {32'd0, BusAddr}, {32'd0, exp_pc});
      cyc();
    end
    BusAck = 1;
    #1;
    check_vec("fetch_ack_nostall", {63'd0, Stall}, 64'd0);
    check_vec("fetch_pc", {32'd0, BusAddr}, {32'd0, exp_pc});
    cyc();
    exp_pc = exp_pc + 32'd4;
    idle();
    cyc();
  endtask

  task automatic exec(input string tag, input logic [1:0] sa, input logic [1:0] sb,
                      input logic [2:0] isrc, input logic [3:0] op, input logic [31:0] exp);
    idle();
    ALUSrcA = sa; ALUSrcB = sb; ImmSrc = isrc; ALUControl = op;
    ResultSrc = RES_ALURESULT; AdrSrc = 1;
    #1;
    check_vec(tag, {32'd0, BusAddr}, {32'd0, exp});
  endtask

  task automatic writeback(input logic [1:0] src);
    idle();
    RegWrite = 1; ResultSrc = src;
    cyc();
    idle();
  endtask

  task automatic store(input string tag, input logic [31:0] word, input logic [31:0] addr,
                       input logic [3:0] be, input logic we, input logic [31:0] wd);
    fetch(word, 0);
    exec({tag, "_addr"}, SRCA_A, SRCB_IMM, IMM_S, ALU_ADD, addr);
    cyc();
    idle();
    AdrSrc = 1; ResultSrc = RES_ALUOUT; MemStrobe = 1; MemWrite = 1; BusAck = 1;
    #1;
    check_vec({tag, "_busaddr"}, {32'd0, BusAddr}, {32'd0, addr});
    check_vec({tag, "_we"}, {63'd0, BusWE}, {63'd0, we});
    check_vec({tag, "_busreq"}, {63'd0, BusReq}, 64'd1);
    if (we) begin
      check_vec({tag, "_be"}, {60'd0, BusBE}, {60'd0, be});
      check_vec({tag, "_wdata"}, {32'd0, BusWData}, {32'd0, wd});
    end
    cyc();
    idle();
  endtask

  task automatic load(input string tag, input logic [31:0] word, input logic [31:0] addr,
                      input logic [31:0] rdata, input logic [31:0] exp);
    fetch(word, 0);
    exec({tag, "_addr"}, SRCA_A, SRCB_IMM, IMM_I, ALU_ADD, addr);
    cyc();
    idle();
    AdrSrc = 1; ResultSrc = RES_ALUOUT; MemStrobe = 1; BusAck = 1; BusRData = rdata;
    #1;
    check_vec({tag, "_be"}, {60'd0, BusBE}, 64'hF);
    check_vec({tag, "_we"}, {63'd0, BusWE}, 64'd0);
    cyc();
    idle();
    AdrSrc = 1; ResultSrc = RES_DATA;
    #1;
    check_vec({tag, "_data"}, {32'd0, BusAddr}, {32'd0, exp});
  endtask

  logic [3:0]  sweep_op  [10] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
                                  ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA};
  logic [31:0] sweep_exp [10] = '{32'hFFFF_FFF4, 32'hFFFF_FFEC, 32'h0000_0000,
                                  32'hFFFF_FFF4, 32'hFFFF_FFF4, 32'h0000_0001,
                                  32'h0000_0000, 32'hFFFF_FF00, 32'h0FFF_FFFF,
                                  32'hFFFF_FFFF};

  initial begin
    n_vec = 0; n_miss = 0; exp_pc = 32'h0;
    RESET = 1;
    idle();
    #2 RESET = 0;
    #1;
    check_vec("rst_pc", {32'd0, BusAddr}, 64'd0);
    check_vec("rst_op", {57'd0, OP}, 64'h13);
    check_vec("rst_stall", {63'd0, Stall}, 64'd0);
    check_vec("rst_busreq", {63'd0, BusReq}, 64'd0);
    AdrSrc = 1;
    #1;
    check_vec("rst_aluout", {32'd0, BusAddr}, 64'd0);
    idle();
    cyc();
    cyc();
    RESET = 1;

    // Fetch with three-cycle ack latency, then addi x1,x0,5
    fetch(32'h0050_0093, 3);
    ImmSrc = IMM_I; ResultSrc = RES_IMMEXT; AdrSrc = 1;
    #1;
    check_vec("fetched_imm", {32'd0, BusAddr}, 64'd5);
    exec("addi_x1", SRCA_A, SRCB_IMM, IMM_I, ALU_ADD, 32'd5);
    cyc();
    writeback(RES_ALUOUT);

    // addi x3,x1,0 reads x1 back; OldPC+4 is the current PC
    fetch(32'h0000_8193, 0);
    exec("read_x1", SRCA_A, SRCB_IMM, IMM_I, ALU_ADD, 32'd5);
    exec("oldpc_plus4", SRCA_OLDPC, SRCB_FOUR, IMM_I, ALU_ADD, exp_pc);

    // addi x0,x0,7 then read x0
    fetch(32'h0070_0013, 0);
    exec("addi_x0", SRCA_A, SRCB_IMM, IMM_I, ALU_ADD, 32'd7);
    cyc();
    writeback(RES_ALUOUT);
    fetch(32'h0000_0193, 0);
    exec("read_x0", SRCA_A, SRCB_IMM, IMM_I, ALU_ADD, 32'd0);

    // x6 = -16, then ALU sweep on A=-16, imm=4 (addi x3,x6,4)
    fetch(32'hFF00_0313, 0);
    exec("addi_x6", SRCA_A, SRCB_IMM, IMM_I, ALU_ADD, 32'hFFFF_FFF0);
    cyc();
    writeback(RES_ALUOUT);
    fetch(32'h0043_0193, 0);
    for (int i = 0; i < 10; i++) begin
      exec($sformatf("alu_op%0d", i), SRCA_A, SRCB_IMM, IMM_I, sweep_op[i], sweep_exp[i]);
    end

    // x2 = 0x12345678 via lui + addi
    fetch(32'h1234_5137, 0);
    ImmSrc = IMM_U; ResultSrc = RES_IMMEXT; AdrSrc = 1;
    #1;
    check_vec("lui_imm", {32'd0, BusAddr}, 64'h1234_5000);
    RegWrite = 1;
    cyc();
    idle();
    fetch(32'h6781_0113, 0);
    exec("addi_x2", SRCA_A, SRCB_IMM, IMM_I, ALU_ADD, 32'h1234_5678);
    cyc();
    writeback(RES_ALUOUT);

    store("sb_103", 32'h1020_01A3, 32'h103, 4'b1000, 1'b1, 32'h7878_7878);
    store("sh_102", 32'h1020_1123, 32'h102, 4'b1100, 1'b1, 32'h5678_5678);
    store("sw_100", 32'h1020_2023, 32'h100, 4'b1111, 1'b1, 32'h1234_5678);
    store("sw_101", 32'h1020_20A3, 32'h101, 4'b0000, 1'b0, 32'h0);

    load("lb_2",  32'h0020_0203, 32'h2, 32'h0080_0000, 32'hFFFF_FF80);
    load("lbu_2", 32'h0020_4203, 32'h2, 32'h0080_0000, 32'h0000_0080);
    load("lh_2",  32'h0020_1203, 32'h2, 32'h8000_0000, 32'hFFFF_8000);
    load("lw_4",  32'h0040_2203, 32'h4, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // sub x5,x1,x1
    fetch(32'h4010_82B3, 0);
    check_vec("sub_op", {57'd0, OP}, 64'h33);
    check_vec("sub_f7b5", {63'd0, funct7b5}, 64'd1);
    exec("sub_res", SRCA_A, SRCB_WDATA, IMM_I, ALU_SUB, 32'd0);
    check_vec("sub_zero", {63'd0, Zero}, 64'd1);
    exec("add_res", SRCA_A, SRCB_WDATA, IMM_I, ALU_ADD, 32'd10);
    check_vec("add_zero", {63'd0, Zero}, 64'd0);

    // Reset in the middle of a stalled load
    fetch(32'h0040_2203, 0);
    exec("lw_stall_addr", SRCA_A, SRCB_IMM, IMM_I, ALU_ADD, 32'h4);
    cyc();
    idle();
    AdrSrc = 1; ResultSrc = RES_ALUOUT; MemStrobe = 1; BusAck = 0;
    #1;
    check_vec("ld_stall", {63'd0, Stall}, 64'd1);
    cyc();
    cyc();
    check_vec("ld_stall_hold", {32'd0, BusAddr}, 64'h4);
    #2 RESET = 0;
    #1;
    check_vec("midrst_aluout", {32'd0, BusAddr}, 64'd0);
    check_vec("midrst_op", {57'd0, OP}, 64'h13);
    AdrSrc = 0;
    #1;
    check_vec("midrst_pc", {32'd0, BusAddr}, 64'd0);
    check_vec("midrst_busreq", {63'd0, BusReq}, 64'd1);
    MemStrobe = 0;
    #1;
    check_vec("midrst_busreq_drop", {63'd0, BusReq}, 64'd0);
    cyc();
    RESET = 1;
    idle();
    cyc();
    check_vec("post_rst_pc", {32'd0, BusAddr}, 64'd0);
    exp_pc = 32'h0;
    fetch(32'h0000_8193, 0);
    exec("x1_cleared", SRCA_A, SRCB_IMM, IMM_I, ALU_ADD, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
